// File: rtl/fir_sym_prog.sv
// Programmable symmetric (linear-phase) FIR with double-buffered coefficients,
// optional decimation and saturation, and a full-precision accumulator tap.
`timescale 1ns/1ps
module fir_sym_prog #(
  parameter int  DW         = 4,
  parameter int  TAPS       = 27,
  parameter int  CW         = 9,
  parameter int  FRAC       = 8,
  parameter int  SATURATION = 1,
  parameter int  DECIM      = 1,
  localparam int NS         = (TAPS + 1) / 2,
  localparam int AD         = $clog2(NS),
  localparam int AW         = DW + 1 + CW + $clog2(NS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          in_valid,
  input  logic          coef_we,
  input  logic [AD-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  input  logic          coef_commit,
  input  logic          sat_clr,
  output logic [DW-1:0] dout,
  output logic          out_valid,
  output logic [AW-1:0] acc_out,
  output logic          sat_flag
);

  localparam int SW  = DW + 1;
  localparam int PW  = DW + 1 + CW;
  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [AW-1:0] R_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] R_MIN = -AW'(2 ** (DW - 1));

  logic signed [DW-1:0] x_sr   [1:TAPS-1];
  logic signed [DW-1:0] x      [TAPS];
  logic signed [SW-1:0] ssum   [NS];
  logic signed [CW-1:0] shadow [NS];
  logic signed [CW-1:0] active [NS];
  logic signed [PW-1:0] prod   [NS];
  logic                 v1;
  logic                 emit1;
  logic [DCW-1:0]       dcnt;
  logic signed [AW-1:0] acc_c;
  logic signed [AW-1:0] r_c;
  logic                 ovf_c;
  logic [DW-1:0]        res_c;
  logic                 emit2;

  // Offset binary to two's complement is just an MSB flip.
  always_comb begin
    x[0] = {~din[DW-1], din[DW-2:0]};
    for (int i = 1; i < TAPS; i++) x[i] = x_sr[i];
  end

  // Fold mirrored taps so each unique coefficient needs only one multiply.
  always_comb begin
    for (int k = 0; k < NS - 1; k++) ssum[k] = SW'(x[k]) + SW'(x[TAPS-1-k]);
    ssum[NS-1] = SW'(x[NS-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < TAPS; i++) x_sr[i] <= '0;
    end else if (in_valid) begin
      for (int i = 1; i < TAPS; i++) x_sr[i] <= x[i-1];
    end
  end

  // NOTE: both coefficient banks are small register files, not RAM, so they
  // can and must be cleared by reset to give a known all-zero filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (coef_commit) begin
        for (int k = 0; k < NS; k++) active[k] <= shadow[k];
      end
      if (coef_we && (int'(coef_addr) < NS)) shadow[coef_addr] <= coef_wdata;
    end
  end

  // Stage 1: products plus valid/emit qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) prod[k] <= '0;
      v1    <= 1'b0;
      emit1 <= 1'b0;
      dcnt  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NS; k++) prod[k] <= PW'(ssum[k]) * PW'(active[k]);
        emit1 <= (dcnt == DCW'(DECIM - 1));
        dcnt  <= (dcnt == DCW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_c = '0;
    for (int k = 0; k < NS; k++) acc_c = acc_c + AW'(prod[k]);
    r_c   = acc_c >>> FRAC;
    ovf_c = (r_c > R_MAX) || (r_c < R_MIN);
    res_c = r_c[DW-1:0];
    if ((SATURATION != 0) && ovf_c) res_c = (r_c > R_MAX) ? R_MAX[DW-1:0] : R_MIN[DW-1:0];
  end

  assign emit2 = v1 & emit1;

  // Stage 2: output register; dout/acc_out only move on emitted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= {1'b1, {(DW-1){1'b0}}};
      out_valid <= 1'b0;
      acc_out   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= emit2;
      if (emit2) begin
        dout    <= {~res_c[DW-1], res_c[DW-2:0]};
        acc_out <= acc_c;
      end
      if (emit2 && ovf_c) sat_flag <= 1'b1;
      else if (sat_clr)   sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_sym_prog.sv
// Self-checking bench for fir_sym_prog: default build (a) and a DECIM=3 wrap
// build (b) share stimulus and are compared each cycle to a convolution model.
`timescale 1ns/1ps
module tb_fir_sym_prog;
  localparam int TAPS = 27;
  localparam int NS   = 14;
  localparam int AW   = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    din;
  logic          in_valid, coef_we, coef_commit, sat_clr;
  logic [3:0]    coef_addr;
  logic [8:0]    coef_wdata;
  logic [3:0]    dout_a, dout_b;
  logic          ov_a, ov_b, sat_a, sat_b;
  logic [AW-1:0] acc_a, acc_b;

  always #5 clk = ~clk;

  fir_sym_prog dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .sat_clr(sat_clr),
    .dout(dout_a), .out_valid(ov_a), .acc_out(acc_a), .sat_flag(sat_a)
  );

  fir_sym_prog #(.DECIM(3), .SATURATION(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .sat_clr(sat_clr),
    .dout(dout_b), .out_valid(ov_b), .acc_out(acc_b), .sat_flag(sat_b)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int oq[$];
  int aq[$];
  int nb = 0;

  // Model: full-length direct-form convolution over a sample history.
  int hist [TAPS-1];
  int shd  [NS];
  int act  [NS];
  int p_acc;
  bit p_v;
  bit p_em   [2];
  int cnt    [2];
  bit e_ovl  [2];
  int e_dout [2];
  int e_acc  [2];
  bit e_sat  [2];

  function automatic int dec_of(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < TAPS - 1; n++) hist[n] = 0;
    for (int k = 0; k < NS; k++) begin
      shd[k] = 0;
      act[k] = 0;
    end
    p_acc = 0;
    p_v   = 1'b0;
    for (int j = 0; j < 2; j++) begin
      p_em[j] = 1'b0; cnt[j] = 0; e_ovl[j] = 1'b0;
      e_dout[j] = 8; e_acc[j] = 0; e_sat[j] = 1'b0;
    end
  endtask

  task automatic model_step();
    int r, xs, acc, dv;
    r = 0;
    for (int j = 0; j < 2; j++) begin
      e_ovl[j] = p_v && p_em[j];
      if (e_ovl[j]) begin
        r = p_acc >>> 8;
        e_acc[j] = p_acc;
        if (j == 0) e_dout[j] = ((r > 7) ? 7 : ((r < -8) ? -8 : r)) + 8;
        else        e_dout[j] = (r + 8) & 15;
      end
      if (e_ovl[j] && (r > 7 || r < -8)) e_sat[j] = 1'b1;
      else if (sat_clr)                  e_sat[j] = 1'b0;
    end
    p_v = in_valid;
    if (in_valid) begin
      xs  = int'(din) - 8;
      acc = xs * act[0];
      for (int n = 1; n < TAPS; n++) acc += hist[n-1] * act[(n < NS) ? n : TAPS - 1 - n];
      p_acc = acc;
      for (int j = 0; j < 2; j++) begin
        dv = dec_of(j);
        p_em[j] = (cnt[j] == dv - 1);
        cnt[j]  = (cnt[j] + 1) % dv;
      end
      for (int n = TAPS - 2; n > 0; n--) hist[n] = hist[n-1];
      hist[0] = xs;
    end
    if (coef_commit) for (int k = 0; k < NS; k++) act[k] = shd[k];
    if (coef_we && int'(coef_addr) < NS) shd[coef_addr] = int'($signed(coef_wdata));
  endtask

  // One clock: drive, let the edge happen, advance the model, return idle.
  task automatic cyc(input bit v, input int d, input bit we = 1'b0, input int a = 0,
                     input int wd = 0, input bit cm = 1'b0, input bit clr = 1'b0);
    in_valid = v; din = 4'(d); coef_we = we; coef_addr = 4'(a);
    coef_wdata = 9'(wd); coef_commit = cm; sat_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; sat_clr = 1'b0;
  endtask

  task automatic quiet_stream(input string nm, input int n);
    int nz;
    oq.delete(); aq.delete();
    for (int i = 0; i < n; i++) cyc(1'b1, (i % 2 != 0) ? 15 : 0);
    repeat (3) cyc(1'b0, 8);
    check({nm, "_count"}, oq.size(), n);
    nz = 0;
    foreach (oq[i]) if (oq[i] != 8) nz++;
    check({nm, "_nonmid"}, nz, 0);
  endtask

  task automatic impulse(input string nm, input int gap);
    int nz;
    oq.delete(); aq.delete();
    for (int i = 0; i < 58; i++) begin
      cyc(1'b1, (i == 27) ? 15 : 8);
      repeat (gap) cyc(1'b0, 8);
    end
    repeat (4) cyc(1'b0, 8);
    check({nm, "_count"}, oq.size(), 58);
    if (oq.size() == 58) begin
      check({nm, "_d0"},  oq[27], 9);
      check({nm, "_d13"}, oq[40], 11);
      check({nm, "_d26"}, oq[53], 9);
      check({nm, "_a0"},  aq[27], 448);
      check({nm, "_a13"}, aq[40], 896);
      check({nm, "_a26"}, aq[53], 448);
      nz = 0;
      for (int i = 28; i < 58; i++) if (i != 40 && i != 53 && oq[i] != 8) nz++;
      check({nm, "_quiet"}, nz, 0);
    end
  endtask

  task automatic reset_literals(input string nm);
    check({nm, "_dout_a"}, dout_a, 8);
    check({nm, "_ov_a"},   ov_a, 0);
    check({nm, "_acc_a"},  int'(acc_a), 0);
    check({nm, "_sat_a"},  sat_a, 0);
    check({nm, "_dout_b"}, dout_b, 8);
    check({nm, "_ov_b"},   ov_b, 0);
    check({nm, "_acc_b"},  int'(acc_b), 0);
    check({nm, "_sat_b"},  sat_b, 0);
  endtask

  // Per-cycle comparison of both builds against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ov_a",   ov_a, int'(e_ovl[0]));
      check("dout_a", dout_a, e_dout[0]);
      check("acc_a",  int'($signed(acc_a)), e_acc[0]);
      check("sat_a",  sat_a, int'(e_sat[0]));
      check("ov_b",   ov_b, int'(e_ovl[1]));
      check("dout_b", dout_b, e_dout[1]);
      check("acc_b",  int'($signed(acc_b)), e_acc[1]);
      check("sat_b",  sat_b, int'(e_sat[1]));
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && ov_a === 1'b1) begin
      oq.push_back(int'(dout_a));
      aq.push_back(int'($signed(acc_a)));
    end
    if (rst_n === 1'b1 && ov_b === 1'b1) nb++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    rst_n = 1'b1; din = 4'd8; in_valid = 1'b0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0; sat_clr = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_literals("rst");
    rst_n = 1'b1;

    // Decimation by 3 on build b: nine samples with random bubbles.
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 3 + i);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 8);
    end
    repeat (4) cyc(1'b0, 8);
    check("decim_pulses", nb, 3);

    quiet_stream("zero_bank", 10);

    cyc(1'b0, 8, 1'b1, 13, 128);
    cyc(1'b0, 8, 1'b1, 0, 64);
    cyc(1'b0, 8, 1'b0, 0, 0, 1'b1);
    impulse("imp", 0);
    impulse("gap", 3);

    // Commit timing with a steady input so each output reflects only the bank.
    oq.delete(); aq.delete();
    for (int i = 0; i < 65; i++) begin
      bit we, cm;
      int a, wd;
      we = 1'b0; cm = 1'b0; a = 0; wd = 0;
      case (i)
        28: begin we = 1'b1; a = 13; wd = 0;   end
        29: begin we = 1'b1; a = 0;  wd = 0;   end
        30: begin we = 1'b1; a = 5;  wd = 255; end
        31: begin we = 1'b1; a = 14; wd = 255; end
        35: cm = 1'b1;
        45: begin we = 1'b1; a = 13; wd = 128; cm = 1'b1; end
        55: cm = 1'b1;
        default: ;
      endcase
      cyc(1'b1, 10, we, a, wd, cm);
    end
    repeat (3) cyc(1'b0, 8);
    check("commit_count", oq.size(), 65);
    if (oq.size() == 65) begin
      for (int i = 27; i < 65; i++)
        check($sformatf("commit_%0d", i), oq[i], (i <= 35) ? 10 : ((i <= 55) ? 11 : 12));
    end

    // Saturation: all coefficients 255, full-scale inputs.
    for (int k = 0; k < NS; k++) cyc(1'b0, 8, 1'b1, k, 255);
    cyc(1'b0, 8, 1'b0, 0, 0, 1'b1);
    repeat (33) cyc(1'b1, 15);
    repeat (3) cyc(1'b0, 8);
    check("sat_hi_dout_a", dout_a, 15);
    check("sat_hi_acc_a",  int'($signed(acc_a)), 48195);
    check("sat_hi_flag_a", sat_a, 1);
    check("wrap_hi_dout_b", dout_b, 4);
    check("wrap_hi_flag_b", sat_b, 1);
    repeat (3) cyc(1'b1, 15, 1'b0, 0, 0, 1'b0, 1'b1);
    check("sat_set_wins", sat_a, 1);
    repeat (3) cyc(1'b0, 8);
    cyc(1'b0, 8, 1'b0, 0, 0, 1'b0, 1'b1);
    check("sat_clr_a", sat_a, 0);
    check("sat_clr_b", sat_b, 0);
    repeat (33) cyc(1'b1, 0);
    repeat (3) cyc(1'b0, 8);
    check("sat_lo_dout_a", dout_a, 0);
    check("sat_lo_acc_a",  int'($signed(acc_a)), -55080);
    check("sat_lo_flag_a", sat_a, 1);
    check("wrap_lo_dout_b", dout_b, 0);

    // Asynchronous reset mid-stream.
    repeat (5) cyc(1'b1, 15);
    in_valid = 1'b1; din = 4'd15;
    #2 rst_n = 1'b0;
    model_reset();
    in_valid = 1'b0;
    #1;
    reset_literals("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    quiet_stream("post_rst", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
